// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between the execute path (requester 0) and the
// branch/compare helper (requester 1). Round-robin valid/ready arbitration
// feeds a single registered result slot (1-cycle latency). Saturating grant
// counters are kept for performance debug.
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_EMPTY | result slot free; any grant fills it
// S_FULL  | result slot holds a result; drains when rsp_ready is high,
//         | refills the same cycle if a new grant is made
module alu_arbiter #(
    parameter int PRIO_INIT = 0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [4:0]       req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [4:0]       req1_shamt,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [31:0]      rsp_c,
    output logic             rsp_cmp,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1
);

    // ALU opcode set shared with the requesters; 13..15 are undefined.
    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOR = 4'd5;
    localparam logic [3:0] ALU_SLL = 4'd6;
    localparam logic [3:0] ALU_SRL = 4'd7;
    localparam logic [3:0] ALU_SRA = 4'd8;
    localparam logic [3:0] ALU_EQ  = 4'd9;
    localparam logic [3:0] ALU_LT  = 4'd10;
    localparam logic [3:0] ALU_LEZ = 4'd11;
    localparam logic [3:0] ALU_LUI = 4'd12;

    typedef enum logic {S_EMPTY, S_FULL} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_prio;
    logic               r_id;
    logic [31:0]        r_c;
    logic               r_cmp;
    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;

    logic               w_can_accept;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_grant;
    logic [3:0]         w_op;
    logic [31:0]        w_a;
    logic [31:0]        w_b;
    logic [4:0]         w_shamt;
    logic [31:0]        w_alu_c;
    logic               w_cmp;

    // Readys are gated by reset so nothing is accepted while it is asserted.
    assign w_can_accept = reset & ((r_state == S_EMPTY) | rsp_ready);
    assign w_gnt0  = w_can_accept & req0_valid & (~req1_valid | (r_prio == 1'b0));
    assign w_gnt1  = w_can_accept & req1_valid & (~req0_valid | (r_prio == 1'b1));
    assign w_grant = w_gnt0 | w_gnt1;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_op    = w_gnt1 ? req1_op    : req0_op;
    assign w_a     = w_gnt1 ? req1_a     : req0_a;
    assign w_b     = w_gnt1 ? req1_b     : req0_b;
    assign w_shamt = w_gnt1 ? req1_shamt : req0_shamt;

    // Shared ALU; compare ops return their flag in bit 0, shifts act on B.
    always_comb begin
        w_alu_c = 32'd0;
        case (w_op)
            ALU_ADD: w_alu_c = w_a + w_b;
            ALU_SUB: w_alu_c = w_a - w_b;
            ALU_AND: w_alu_c = w_a & w_b;
            ALU_OR:  w_alu_c = w_a | w_b;
            ALU_XOR: w_alu_c = w_a ^ w_b;
            ALU_NOR: w_alu_c = ~(w_a | w_b);
            ALU_SLL: w_alu_c = w_b << w_shamt;
            ALU_SRL: w_alu_c = w_b >> w_shamt;
            ALU_SRA: w_alu_c = $unsigned($signed(w_b) >>> w_shamt);
            ALU_EQ:  w_alu_c = {31'd0, (w_a == w_b)};
            ALU_LT:  w_alu_c = {31'd0, ($signed(w_a) < $signed(w_b))};
            ALU_LEZ: w_alu_c = {31'd0, ($signed(w_a) <= 32'sd0)};
            ALU_LUI: w_alu_c = {w_b[15:0], 16'd0};
            default: w_alu_c = 32'd0;
        endcase
    end

    // Compare flag taken from C[0] for compare ops only.
    assign w_cmp = ((w_op == ALU_EQ) | (w_op == ALU_LT) | (w_op == ALU_LEZ)) & w_alu_c[0];

    // Slot state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_EMPTY;
        else        r_state <= w_state_nxt;
    end

    // Slot next-state: fill on grant, drain on rsp_ready without a refill.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_EMPTY: if (w_grant) w_state_nxt = S_FULL;
            S_FULL:  if (rsp_ready && !w_grant) w_state_nxt = S_EMPTY;
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    // Result slot capture and round-robin pointer update on every grant.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_c    <= 32'd0;
            r_cmp  <= 1'b0;
            r_id   <= 1'b0;
            r_prio <= (PRIO_INIT != 0);
        end else if (w_grant) begin
            r_c    <= w_alu_c;
            r_cmp  <= w_cmp;
            r_id   <= w_gnt1;
            r_prio <= w_gnt0;
        end
    end

    // Saturating grant counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0 && (r_cnt0 != {CNT_W{1'b1}})) r_cnt0 <= r_cnt0 + CNT_W'(1);
            if (w_gnt1 && (r_cnt1 != {CNT_W{1'b1}})) r_cnt1 <= r_cnt1 + CNT_W'(1);
        end
    end

    assign rsp_valid  = (r_state == S_FULL);
    assign rsp_id     = r_id;
    assign rsp_c      = r_c;
    assign rsp_cmp    = r_cmp;
    assign grant_cnt0 = r_cnt0;
    assign grant_cnt1 = r_cnt1;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one ALU instance between two requesters: requester 0 is the main execute path, requester 1 is the branch/compare helper.
- Uses valid/ready handshakes with round-robin arbitration.
- Holds one registered result slot, so each response arrives one cycle after acceptance.
- Keeps saturating per-requester grant counters for performance debug.

Parameters:
- PRIO_INIT, 0, requester that holds priority after reset (0 or 1).
- CNT_W, 16, width of each saturating grant counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- req0_valid  in  1  requester 0 presents an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  4  ALU opcode from the const.v ALU_* set.
- req0_a  in  32  operand A.
- req0_b  in  32  operand B.
- req0_shamt  in  5  shift amount.
- req1_valid / req1_ready / req1_op / req1_a / req1_b / req1_shamt  same as requester 0, for requester 1.
- rsp_valid  out  1  result slot holds a valid result.
- rsp_id  out  1  requester that owns the held result.
- rsp_c  out  32  registered ALU result C.
- rsp_cmp  out  1  registered compare flag.
- rsp_ready  in  1  consumer takes the result this cycle.
- grant_cnt0  out  CNT_W  number of requester 0 grants, saturating.
- grant_cnt1  out  CNT_W  number of requester 1 grants, saturating.

Behaviour:
- Reset (reset==0, asynchronous): all outputs go to their reset values immediately.
  - rsp_valid=0, rsp_id=0, rsp_c=0, rsp_cmp=0, grant_cnt0=0, grant_cnt1=0.
  - Priority pointer prio=PRIO_INIT. req0_ready and req1_ready are 0 while reset is asserted.
- Slot state machine:
  - EMPTY: rsp_valid=0. A grant moves it to FULL.
  - FULL: rsp_valid=1.
    - rsp_ready=1 with no new grant moves it to EMPTY.
    - rsp_ready=1 with a same-cycle grant stays FULL with the new result (back-to-back operation).
    - rsp_ready=0 holds rsp_id, rsp_c and rsp_cmp stable.
- can_accept = EMPTY or (FULL and rsp_ready).
- Arbitration (combinational, in the same cycle):
  - Only requester 0 valid: grant 0. Only requester 1 valid: grant 1.
  - Both valid: grant requester prio.
  - No grant when can_accept=0.
- reqN_ready = can_accept and granted N. It must not depend on the other requester's ready; it may depend on both valids.
- Handshake:
  - A transfer occurs when reqN_valid and reqN_ready are both 1.
  - Requesters must hold op, a, b and shamt stable while valid is high and ready is low.
- Datapath:
  - The granted requester's op, a, b and shamt are muxed into a single internal ALU.
  - C is captured into rsp_c at the grant edge, so latency is exactly 1 cycle: accepted at edge N, rsp_valid=1 after edge N.
- rsp_cmp:
  - For ALU_eq, ALU_lt and ALU_lez, capture C[0].
  - For every other op, capture 0. The ALU cmp output is not used, because it is only defined for compare ops.
- Undefined opcodes return C=0 and rsp_cmp=0, and still count as grants.
- prio update: after any grant to requester N, prio becomes 1-N. It is unchanged when there is no grant.
- Grant counters: +1 on each grant to their requester, saturating at all-ones with no wrap.
- Reset asserted while FULL or mid-handshake: the held result is discarded, nothing is replayed, and counters clear.

Test Plan:
- Reset behaviour: drive reset=0 for 3 cycles with req0_valid=1 -> rsp_valid=0, req0_ready=0, both counters 0; after release, first grant goes to PRIO_INIT.
- Single op: req0 add, a=5, b=7, rsp_ready=1 -> req0_ready=1 in cycle N; rsp_valid=1, rsp_id=0, rsp_c=12, rsp_cmp=0 in cycle N+1.
- Contention: both valid every cycle, rsp_ready=1, req0 sub a=10 b=3, req1 lt a=0xFFFFFFFF b=1 -> grants alternate 0,1,0,1 with one grant per cycle; responses alternate rsp_c=7, then rsp_c=1 with rsp_cmp=1.
- Backpressure: hold rsp_ready=0 for 4 cycles after one result -> rsp_c and rsp_id stay stable, both readys stay 0; raising rsp_ready with req1 sll b=1 shamt=4 pending -> same-cycle accept, next rsp_c=16.
- Compare ops: eq a=b=0x80000000 -> rsp_cmp=1; lez a=0 -> rsp_cmp=1; lez a=1 -> rsp_cmp=0; srl b=0x80000000 shamt=31 -> rsp_c=1, rsp_cmp=0.
- Saturation and async reset: with CNT_W=2, make 5 grants to req0 -> grant_cnt0 saturates at 3; assert reset mid-cycle while FULL -> rsp_valid drops to 0 without waiting for a clock edge.
